class_vote_decoder: RTL

// - Consumes the one-hot texture-class stream produced by the MRELBP classifier (5 classes).
// - Decodes each beat to a class index and accumulates per-class votes over a frame of windows.
// - At frame end, reports the majority label through a valid/ready result interface.
// - Sits between the classifier output register and the result/display logic.

---
 rtl/mrelbp_cls_pkg.sv | 23 ++
 rtl/onehot_to_idx.sv | 21 ++
 rtl/class_vote_decoder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mrelbp_cls_pkg.sv
// Shared constants and types for the MRELBP texture-class vote stage.
// Class count, label encoding and vote FSM states.
package mrelbp_cls_pkg;

  localparam int NUM_CLASSES = 5;

  typedef enum logic [2:0] {
    BLANKET = 3'd0,
    CANVAS  = 3'd1,
    CEILING = 3'd2,
    CUSHION = 3'd3,
    FLOOR   = 3'd4
  } class_e;

  localparam logic [2:0] LABEL_NONE = 3'd7;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    SCAN   = 2'd1,
    OUTPUT = 2'd2
  } vote_state_e;

endpackage

// File: rtl/onehot_to_idx.sv
// One-hot class beat to binary index.
// o_ok flags beats with exactly one bit set.
module onehot_to_idx #(
  parameter int N = mrelbp_cls_pkg::NUM_CLASSES
) (
  input  logic [N-1:0] i_onehot,
  output logic [2:0]   o_idx,
  output logic         o_ok
);
  import mrelbp_cls_pkg::*;

  always_comb begin
    o_idx = LABEL_NONE;
    for (int i = 0; i < N; i++) begin
      if (i_onehot[i]) o_idx = 3'(i);
    end
  end

  assign o_ok = ($countones(i_onehot) == 1);

endmodule

// File: rtl/class_vote_decoder.sv
// Per-frame majority vote over one-hot class beats.
// Accumulate, scan one class per cycle, then hold the result until taken.
module class_vote_decoder #(
  parameter int NUM_CLASSES = mrelbp_cls_pkg::NUM_CLASSES,
  parameter int CNT_W       = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [NUM_CLASSES-1:0] i_onehot,
  input  logic                   i_last,
  output logic                   o_in_ready,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [2:0]             o_label,
  output logic [NUM_CLASSES-1:0] o_label_onehot,
  output logic [CNT_W-1:0]       o_votes,
  output logic [CNT_W-1:0]       o_total,
  output logic [CNT_W-1:0]       o_err_cnt
);
  import mrelbp_cls_pkg::*;

  vote_state_e            state;
  logic [CNT_W-1:0]       votes [NUM_CLASSES];
  logic [CNT_W-1:0]       total;
  logic [CNT_W-1:0]       err_cnt;
  logic [CNT_W-1:0]       best_cnt;
  logic [2:0]             best_idx;
  logic [2:0]             scan_k;
  logic [2:0]             beat_idx;
  logic                   beat_ok;
  logic                   accept;
  logic [NUM_CLASSES-1:0] best_oh;

  onehot_to_idx #(
    .N (NUM_CLASSES)
  ) u_dec (
    .i_onehot (i_onehot),
    .o_idx    (beat_idx),
    .o_ok     (beat_ok)
  );

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign o_in_ready = (state == ACCUM);
  assign accept     = i_valid & o_in_ready;

  // LABEL_NONE matches no position, so it maps to all zeros
  always_comb begin
    best_oh = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      best_oh[i] = (best_idx == 3'(i));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= ACCUM;
      for (int i = 0; i < NUM_CLASSES; i++) votes[i] <= '0;
      total    <= '0;
      err_cnt  <= '0;
      scan_k   <= '0;
      best_idx <= LABEL_NONE;
      best_cnt <= '0;
      o_valid  <= 1'b0;
      o_label  <= LABEL_NONE;
      o_label_onehot <= '0;
      o_votes   <= '0;
      o_total   <= '0;
      o_err_cnt <= '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            if (beat_ok) begin
              votes[beat_idx] <= sat_inc(votes[beat_idx]);
              total <= sat_inc(total);
            end else begin
              err_cnt <= sat_inc(err_cnt);
            end
            if (i_last) begin
              state    <= SCAN;
              scan_k   <= '0;
              best_idx <= LABEL_NONE;
              best_cnt <= '0;
            end
          end
        end
        SCAN: begin
          // strict compare: ties keep the lower index
          if (votes[scan_k] > best_cnt) begin
            best_idx <= scan_k;
            best_cnt <= votes[scan_k];
          end
          scan_k <= scan_k + 3'd1;
          if (scan_k == 3'(NUM_CLASSES - 1)) state <= OUTPUT;
        end
        OUTPUT: begin
          if (!o_valid) begin
            o_valid        <= 1'b1;
            o_label        <= best_idx;
            o_label_onehot <= best_oh;
            o_votes        <= best_cnt;
            o_total        <= total;
            o_err_cnt      <= err_cnt;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            state   <= ACCUM;
            for (int i = 0; i < NUM_CLASSES; i++) votes[i] <= '0;
            total   <= '0;
            err_cnt <= '0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
